// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, the write-back entry record, the result-source
// enumeration and a register-index legality helper for the write-back stage.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 7;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [IDX_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MEM
  } wb_src_e;

  // Only indices below NREGS map onto an implemented register.
  function automatic logic idx_legal(input logic [IDX_W-1:0] rd);
    return rd < IDX_W'(NREGS);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t used to buffer memory results.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   push, din     - enqueue din (ignored while full)
//   pop, dout     - dequeue; dout is the current head (valid while !empty)
//   full, empty   - occupancy flags
//   count         - number of stored entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  din,
  input  logic                       pop,
  output wb_entry_t                  dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; occupancy is tracked solely by count.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results (fixed latency, no backpressure) and
// buffered memory results (valid/ready) into one registered register-file
// write per clock, and keeps a pending-write scoreboard for hazard checks.
// Ports:
//   clock, reset                   - rising-edge clock, sync active-high reset
//   alu_valid/alu_rd/alu_data      - ALU result; always wins arbitration
//   alu_stall                      - ask upstream to hold off ALU results
//   mem_valid/mem_rd/mem_data      - memory result offer
//   mem_ready                      - offer accepted when mem_valid && mem_ready
//   issue_valid/issue_rd           - decode marks a destination as pending
//   wr_en/wr_addr/wr_data          - registered write port toward decode
//   pending                        - per-register outstanding-write bits
//   proto_err                      - sticky protocol-violation flag
module writeback_unit
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_DEFER  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [IDX_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_stall,
  input  logic              mem_valid,
  input  logic [IDX_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [IDX_W-1:0]  issue_rd,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREGS-1:0]  pending,
  output logic              proto_err
);

  localparam int DW   = $clog2(MAX_DEFER + 1);
  localparam int SB_W = $clog2(NREGS);

  wb_entry_t                       mem_entry;
  wb_entry_t                       fifo_head;
  wb_entry_t                       sel_entry;
  wb_src_e                         sel;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic                            mem_push;
  logic                            fifo_pop;
  logic [DW-1:0]                   defer_cnt;
  logic [DW-1:0]                   defer_next;
  logic [NREGS-1:0]                pending_next;
  logic                            err_now;

  assign mem_ready       = !fifo_full;
  assign mem_push        = mem_valid && mem_ready;
  assign mem_entry.rd    = mem_rd;
  assign mem_entry.data  = mem_data;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (mem_push),
    .din   (mem_entry),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ALU has absolute priority; the FIFO drains only in ALU-idle cycles.
  always_comb begin
    sel            = WB_NONE;
    sel_entry.rd   = alu_rd;
    sel_entry.data = alu_data;
    if (alu_valid) begin
      sel = WB_ALU;
    end else if (!fifo_empty) begin
      sel       = WB_MEM;
      sel_entry = fifo_head;
    end
  end

  assign fifo_pop = (sel == WB_MEM);

  // Counts ALU-won cycles while memory data waits; any pop or an empty
  // FIFO means nothing is being starved.
  always_comb begin
    defer_next = defer_cnt;
    if (fifo_pop || fifo_empty) begin
      defer_next = '0;
    end else if (alu_valid && (defer_cnt != DW'(MAX_DEFER))) begin
      defer_next = defer_cnt + 1'b1;
    end
  end

  // Clear for the selected write, then set for the new issue so that a
  // same-index set overrides the clear.
  always_comb begin
    pending_next = pending;
    if ((sel != WB_NONE) && idx_legal(sel_entry.rd)) begin
      pending_next[sel_entry.rd[SB_W-1:0]] = 1'b0;
    end
    if (issue_valid && idx_legal(issue_rd)) begin
      pending_next[issue_rd[SB_W-1:0]] = 1'b1;
    end
  end

  assign err_now = (alu_valid && alu_stall)
                || (alu_valid && !idx_legal(alu_rd))
                || (mem_push && !idx_legal(mem_rd))
                || (issue_valid && !idx_legal(issue_rd));

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      alu_stall <= 1'b0;
      proto_err <= 1'b0;
      pending   <= '0;
      defer_cnt <= '0;
    end else begin
      wr_en <= (sel != WB_NONE);
      if (sel != WB_NONE) begin
        wr_addr <= sel_entry.rd;
        wr_data <= sel_entry.data;
      end
      defer_cnt <= defer_next;
      alu_stall <= (defer_next == DW'(MAX_DEFER));
      pending   <= pending_next;
      if (err_now) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  import wb_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic [IDX_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;
  logic              mem_valid;
  logic [IDX_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              issue_valid;
  logic [IDX_W-1:0]  issue_rd;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREGS-1:0]  pending;
  logic              proto_err;

  always #5 clock = ~clock;

  writeback_unit #(.FIFO_DEPTH(4), .MAX_DEFER(4)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending(pending), .proto_err(proto_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  wb_entry_t         mq[$];
  int                m_defer;
  bit                m_stall, m_proto, m_wr_en;
  logic [IDX_W-1:0]  m_wr_addr;
  logic [DATA_W-1:0] m_wr_data;
  logic [NREGS-1:0]  m_pend;

  function automatic bit legal(input logic [IDX_W-1:0] r);
    return int'(r) < 32;
  endfunction

  task automatic model_step();
    wb_entry_t w, e;
    bit wrote, popped, was_empty, accept;
    if (reset) begin
      mq.delete();
      m_defer = 0; m_stall = 0; m_proto = 0; m_wr_en = 0;
      m_wr_addr = '0; m_wr_data = '0; m_pend = '0;
      return;
    end
    accept    = mem_valid && (mq.size() < 4);
    was_empty = (mq.size() == 0);
    wrote = 0; popped = 0; w = '0;
    if (alu_valid) begin
      w.rd = alu_rd; w.data = alu_data; wrote = 1;
    end else if (!was_empty) begin
      w = mq.pop_front(); wrote = 1; popped = 1;
    end
    if (alu_valid && m_stall) m_proto = 1;
    if (alu_valid && !legal(alu_rd)) m_proto = 1;
    if (accept && !legal(mem_rd)) m_proto = 1;
    if (issue_valid && !legal(issue_rd)) m_proto = 1;
    if (popped || was_empty) m_defer = 0;
    else if (alu_valid && m_defer < 4) m_defer++;
    m_stall = (m_defer == 4);
    if (wrote && legal(w.rd)) m_pend[w.rd[4:0]] = 1'b0;
    if (issue_valid && legal(issue_rd)) m_pend[issue_rd[4:0]] = 1'b1;
    m_wr_en = wrote;
    if (wrote) begin m_wr_addr = w.rd; m_wr_data = w.data; end
    if (accept) begin e.rd = mem_rd; e.data = mem_data; mq.push_back(e); end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("m_wr_en",     wr_en,     m_wr_en);
    chk("m_wr_addr",   wr_addr,   m_wr_addr);
    chk("m_wr_data",   wr_data,   m_wr_data);
    chk("m_mem_ready", mem_ready, mq.size() < 4);
    chk("m_alu_stall", alu_stall, m_stall);
    chk("m_proto_err", proto_err, m_proto);
    chk("m_pending",   pending,   m_pend);
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
  endtask
  task automatic set_alu(input int rd, input logic [31:0] d);
    alu_valid = 1; alu_rd = IDX_W'(rd); alu_data = d;
  endtask
  task automatic set_mem(input int rd, input logic [31:0] d);
    mem_valid = 1; mem_rd = IDX_W'(rd); mem_data = d;
  endtask
  task automatic set_issue(input int rd);
    issue_valid = 1; issue_rd = IDX_W'(rd);
  endtask
  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_pending", pending, 0);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_proto", proto_err, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        av; logic [6:0] ard; logic [31:0] ad;
    logic        mv; logic [6:0] mrd; logic [31:0] md;
    logic        we; logic [6:0] wa;  logic [31:0] wd;
    logic        rdy; logic stall;
  } vec_t;

  function automatic vec_t mk(input logic av, input int ard, input logic [31:0] ad,
                              input logic mv, input int mrd, input logic [31:0] md,
                              input logic we, input int wa, input logic [31:0] wd,
                              input logic rdy, input logic stall);
    vec_t v;
    v.av = av; v.ard = 7'(ard); v.ad = ad;
    v.mv = mv; v.mrd = 7'(mrd); v.md = md;
    v.we = we; v.wa = 7'(wa); v.wd = wd; v.rdy = rdy; v.stall = stall;
    return v;
  endfunction

  vec_t tv[15];

  initial begin
    reset = 1; idle();
    alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0; issue_rd = '0;

    //            alu          mem                         expected write      rdy stall
    tv[0]  = mk(1, 5, 32'hAA,  0, 0, 0,                    1, 5, 32'hAA,       1, 0);
    tv[1]  = mk(0, 0, 0,       0, 0, 0,                    0, 5, 32'hAA,       1, 0);
    tv[2]  = mk(0, 0, 0,       1, 9, 32'hDEAD_BEEF,        0, 5, 32'hAA,       1, 0);
    tv[3]  = mk(0, 0, 0,       0, 0, 0,                    1, 9, 32'hDEAD_BEEF,1, 0);
    tv[4]  = mk(0, 0, 0,       0, 0, 0,                    0, 9, 32'hDEAD_BEEF,1, 0);
    tv[5]  = mk(1, 1, 32'h11,  1, 10, 32'h100,             1, 1, 32'h11,       1, 0);
    tv[6]  = mk(1, 2, 32'h22,  1, 11, 32'h101,             1, 2, 32'h22,       1, 0);
    tv[7]  = mk(1, 3, 32'h33,  1, 12, 32'h102,             1, 3, 32'h33,       1, 0);
    tv[8]  = mk(1, 4, 32'h44,  1, 13, 32'h103,             1, 4, 32'h44,       0, 0);
    tv[9]  = mk(1, 6, 32'h66,  1, 14, 32'h104,             1, 6, 32'h66,       0, 1);
    tv[10] = mk(0, 0, 0,       0, 0, 0,                    1, 10, 32'h100,     1, 0);
    tv[11] = mk(0, 0, 0,       0, 0, 0,                    1, 11, 32'h101,     1, 0);
    tv[12] = mk(0, 0, 0,       0, 0, 0,                    1, 12, 32'h102,     1, 0);
    tv[13] = mk(0, 0, 0,       0, 0, 0,                    1, 13, 32'h103,     1, 0);
    tv[14] = mk(0, 0, 0,       0, 0, 0,                    0, 13, 32'h103,     1, 0);

    tick(); tick();
    reset = 0;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_stall", alu_stall, 0);
    chk("reset_proto", proto_err, 0);
    chk("reset_pending", pending, 0);
    chk("reset_ready", mem_ready, 1);

    for (int i = 0; i < 15; i++) begin
      idle();
      alu_valid = tv[i].av; alu_rd = tv[i].ard; alu_data = tv[i].ad;
      mem_valid = tv[i].mv; mem_rd = tv[i].mrd; mem_data = tv[i].md;
      tick();
      chk($sformatf("tv%0d_wr_en", i), wr_en, tv[i].we);
      chk($sformatf("tv%0d_wr_addr", i), wr_addr, tv[i].wa);
      chk($sformatf("tv%0d_wr_data", i), wr_data, tv[i].wd);
      chk($sformatf("tv%0d_ready", i), mem_ready, tv[i].rdy);
      chk($sformatf("tv%0d_stall", i), alu_stall, tv[i].stall);
    end
    idle();

    // Starvation: one buffered entry, ALU busy for 4 cycles.
    do_reset();
    set_alu(1, 32'h1); set_mem(20, 32'hCAFE); tick();
    chk("starve_stall0", alu_stall, 0);
    mem_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      set_alu(i + 1, 32'(i)); tick();
      chk($sformatf("starve_stall_%0d", i), alu_stall, i == 4);
    end
    idle(); tick();
    chk("starve_wr_en", wr_en, 1);
    chk("starve_wr_addr", wr_addr, 20);
    chk("starve_wr_data", wr_data, 32'hCAFE);
    chk("starve_stall_cleared", alu_stall, 0);
    chk("starve_proto", proto_err, 0);

    // ALU result during stall: still written, error flagged and sticky.
    do_reset();
    set_alu(1, 32'h1); set_mem(21, 32'hBEEF); tick();
    mem_valid = 0;
    for (int i = 0; i < 4; i++) begin set_alu(2, 32'h2); tick(); end
    chk("err_stall_up", alu_stall, 1);
    set_alu(8, 32'h88); tick();
    chk("err_wr_en", wr_en, 1);
    chk("err_wr_addr", wr_addr, 8);
    chk("err_wr_data", wr_data, 32'h88);
    chk("err_proto", proto_err, 1);
    idle();
    for (int i = 0; i < 3; i++) begin tick(); chk("err_sticky", proto_err, 1); end

    // Scoreboard set/clear and set-wins.
    do_reset();
    set_issue(3); tick();
    chk("sb_set3", pending[3], 1);
    idle(); set_alu(3, 32'h33); tick();
    chk("sb_clr_wr_en", wr_en, 1);
    chk("sb_clr3", pending[3], 0);
    set_alu(3, 32'h34); set_issue(3); tick();
    chk("sb_setwins_wr", wr_en, 1);
    chk("sb_setwins3", pending[3], 1);
    idle(); set_issue(7); tick();
    idle(); set_issue(40); tick();
    chk("illegal_issue_proto", proto_err, 1);
    chk("illegal_issue_pending", pending, 32'h0000_0088);
    idle(); tick();

    // Reset while the FIFO holds three entries.
    do_reset();
    set_alu(1, 32'h1); set_mem(21, 32'h21); set_issue(4); tick();
    issue_valid = 0;
    set_alu(2, 32'h2); set_mem(22, 32'h22); tick();
    set_alu(3, 32'h3); set_mem(23, 32'h23); tick();
    idle(); reset = 1; tick(); reset = 0;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_ready", mem_ready, 1);
    for (int i = 0; i < 3; i++) begin tick(); chk("midrst_no_write", wr_en, 0); end

    // Random, well-behaved traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      idle();
      if (!m_stall && $urandom_range(0, 99) < 55) set_alu($urandom_range(0, 31), $urandom);
      if ($urandom_range(0, 99) < 50) set_mem($urandom_range(0, 31), $urandom);
      if ($urandom_range(0, 99) < 40) set_issue($urandom_range(0, 31));
      tick();
    end

    // Random traffic with protocol violations and occasional resets.
    for (int i = 0; i < 600; i++) begin
      idle();
      reset = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 60) set_alu($urandom_range(0, 39), $urandom);
      if ($urandom_range(0, 99) < 50) set_mem($urandom_range(0, 39), $urandom);
      if ($urandom_range(0, 99) < 40) set_issue($urandom_range(0, 39));
      tick();
    end
    reset = 0; idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
